// File: rtl/gray_ptr_rx.sv
// -----------------------------------------------------------------------------
// gray_ptr_rx
//
// Receive side of a gray-coded FIFO pointer crossing into the clk_i domain.
// The remote gray pointer passes through a SyncStages-deep synchroniser, is
// converted to binary, and is compared against the local binary pointer to
// produce a registered fill level and status flags.
//
// Optional feature (macro GRAY_CHECK_EN): when defined, the synchronised gray
// value is checked against its previous value and gray_err_o latches when
// more than one bit changed between consecutive samples. When undefined,
// gray_err_o is tied low.
//
// Ports:
//   clk_i          receive-domain clock, rising edge
//   rst_i          asynchronous reset, active high
//   remote_gray_i  gray pointer from the remote domain (one bit change per update)
//   local_bin_i    local binary pointer, synchronous to clk_i
//   remote_bin_o   synchronised remote pointer, binary
//   level_o        (remote_bin - local_bin) mod 2**PtrWidth
//   empty_o        level_o == 0
//   full_o         level_o == Depth, Depth = 2**(PtrWidth-1)
//   overflow_o     sticky: a level above Depth was computed
//   gray_err_o     sticky: synchronised gray code moved by more than one bit
// -----------------------------------------------------------------------------
module gray_ptr_rx #(
    parameter int unsigned PtrWidth   = 5,
    parameter int unsigned SyncStages = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [PtrWidth-1:0] remote_gray_i,
    input  logic [PtrWidth-1:0] local_bin_i,
    output logic [PtrWidth-1:0] remote_bin_o,
    output logic [PtrWidth-1:0] level_o,
    output logic                empty_o,
    output logic                full_o,
    output logic                overflow_o,
    output logic                gray_err_o
);

    // Depth = 2**(PtrWidth-1), built as a bit pattern so it stays valid up to
    // PtrWidth == 32 without signed-int overflow.
    localparam logic [PtrWidth-1:0] DepthPtr = {1'b1, {(PtrWidth - 1){1'b0}}};

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    function automatic logic [PtrWidth-1:0] g2b(input logic [PtrWidth-1:0] g);
        logic [PtrWidth-1:0] b;
        b = '0;
        for (int i = 0; i < PtrWidth; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Synchroniser chain; sync[0] is the first flop after the crossing.
    logic [SyncStages-1:0][PtrWidth-1:0] sync;
    logic [PtrWidth-1:0]                 sync_out;
    logic [PtrWidth-1:0]                 sync_bin;
    logic [PtrWidth-1:0]                 level_next;
    logic                                ovf_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync <= '0;
        end else begin
            sync[0] <= remote_gray_i;
            for (int k = 1; k < SyncStages; k++) begin
                sync[k] <= sync[k-1];
            end
        end
    end

    always_comb begin
        sync_out   = sync[SyncStages-1];
        sync_bin   = g2b(sync_out);
        // Modulo subtraction handles pointer wrap-around for free.
        level_next = sync_bin - local_bin_i;
        ovf_next   = (level_next > DepthPtr);
    end

    // Output register stage, updated every edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            remote_bin_o <= '0;
            level_o      <= '0;
            empty_o      <= 1'b1;
            full_o       <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            remote_bin_o <= sync_bin;
            level_o      <= level_next;
            empty_o      <= (level_next == '0);
            full_o       <= (level_next == DepthPtr);
            overflow_o   <= overflow_o | ovf_next;
        end
    end

`ifdef GRAY_CHECK_EN
    logic [PtrWidth-1:0] prev_gray;
    logic                gray_err;

    // Compares consecutive synchronised samples, so the flag lands on the same
    // edge as the remote_bin_o value that exposed it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_gray <= '0;
            gray_err  <= 1'b0;
        end else begin
            prev_gray <= sync_out;
            gray_err  <= gray_err | ($countones(sync_out ^ prev_gray) > 1);
        end
    end

    assign gray_err_o = gray_err;
`else
    assign gray_err_o = 1'b0;
`endif

endmodule
